// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus plus the board SRAM pins, bundled for the SRAM responder.
// Latency: none, wiring only.
// Backpressure: ready low stalls the requester; SRAM side has no flow control.
interface sram_controller_if #(
    parameter int unsigned SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic               sram_dq_oe;
    logic [15:0]        sram_dq_in;
    logic               sram_we_n;
    logic               sram_oe_n;

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );
endinterface

// File: rtl/sram_controller.sv
// 32-bit word load/store responder that splits each access into two 16-bit SRAM accesses.
// Latency: 2*HALF_CYCLES+1 cycles with ready low, then ready high for one DONE cycle.
// Backpressure: ready=0 while busy; the pipeline freezes on ~ready, request inputs are ignored once latched.
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned HALF_CYCLES = 2,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    sram_controller_if.slave     bus
);

    localparam int unsigned CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
    localparam int unsigned WW = SRAM_AW - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic          op_wr;
    logic [WW-1:0] word;
    logic [31:0]   wdata;
    logic [15:0]   lo_q;
    logic [31:0]   rdata;

    logic          req;
    logic          last;
    logic [31:0]   offset;
    logic          active;
    logic          unused_addr_bits;

    assign req    = bus.wr_en | bus.rd_en;
    assign last   = (cnt == CNT_LAST);
    assign offset = bus.address - 32'(BASE_ADDR);
    assign active = (state == S_LOW) || (state == S_HIGH);

    // Byte lane bits and word bits above the SRAM range are dropped on purpose.
    assign unused_addr_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end
            end
            S_LOW: begin
                if (last) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (last) begin
                    state_nxt = S_DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Request latches and read assembly; the high half goes straight into read_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_wr <= 1'b0;
            word  <= '0;
            wdata <= '0;
            lo_q  <= '0;
            rdata <= '0;
        end else begin
            if ((state == S_IDLE) && req) begin
                op_wr <= bus.wr_en;
                word  <= offset[WW+1:2];
                wdata <= bus.write_data;
            end
            if ((state == S_LOW) && last && !op_wr) begin
                lo_q <= bus.sram_dq_in;
            end
            if ((state == S_HIGH) && last && !op_wr) begin
                rdata <= {bus.sram_dq_in, lo_q};
            end
        end
    end

    // SRAM pins decode from registered state only, so reset idles them immediately.
    always_comb begin
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        if (active) begin
            bus.sram_addr = {word, (state == S_HIGH)};
            if (op_wr) begin
                bus.sram_dq_out = (state == S_HIGH) ? wdata[31:16] : wdata[15:0];
                bus.sram_dq_oe  = 1'b1;
                bus.sram_we_n   = 1'b0;
            end else begin
                bus.sram_oe_n   = 1'b0;
            end
        end
    end

    assign bus.ready     = (state == S_DONE) || ((state == S_IDLE) && !req);
    assign bus.read_data = rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small SRAM model and a read-data scoreboard.
module tb_sram_controller;

    localparam int HC = 2;

    logic clk;
    logic rst;
    logic mem_init;

    sram_controller_if #(.SRAM_AW(18)) bus ();

    sram_controller #(
        .BASE_ADDR  (1024),
        .HALF_CYCLES(HC),
        .SRAM_AW    (18)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board SRAM model: 16 locations, write on rising edge while we_n is low.
    logic [15:0] mem [16];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h1000 + 16'(i);
        end else if (!bus.sram_we_n) begin
            mem[bus.sram_addr[3:0]] <= bus.sram_dq_out;
        end
    end
    assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0000 : mem[bus.sram_addr[3:0]];

    logic [15:0] ref_mem [16];
    logic [31:0] rdq [$];

    int n_cmp = 0;
    int n_mis = 0;

    int          lat;
    logic [31:0] a_lo, a_hi, d_lo, d_hi;
    logic        any_oe, any_we, any_dqoe, s0_we, s0_oe;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_mem%0d", tag, i), {16'h0, mem[i]}, {16'h0, ref_mem[i]});
        end
    endtask

    // Drives a request and follows it to the DONE cycle (returns at that negedge, request still held).
    task automatic access(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] data, input string tag);
        int   w;
        logic done;
        logic [31:0] exp;
        bus.wr_en      = wr;
        bus.rd_en      = rd;
        bus.address    = addr;
        bus.write_data = data;
        w = int'(((addr - 32'd1024) >> 2) & 32'h7);
        if (wr) begin
            ref_mem[2*w]   = data[15:0];
            ref_mem[2*w+1] = data[31:16];
        end else if (rd) begin
            rdq.push_back({ref_mem[2*w+1], ref_mem[2*w]});
        end
        lat = 0; any_oe = 0; any_we = 0; any_dqoe = 0; s0_we = 1; s0_oe = 1;
        a_lo = '1; a_hi = '1; d_lo = '1; d_hi = '1;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                done = 1'b1;
            end else begin
                if (lat == 0) begin s0_we = bus.sram_we_n; s0_oe = bus.sram_oe_n; end
                if (lat == 1) begin a_lo = 32'(bus.sram_addr); d_lo = {16'h0, bus.sram_dq_out}; end
                if (lat == 1 + HC) begin a_hi = 32'(bus.sram_addr); d_hi = {16'h0, bus.sram_dq_out}; end
                if (!bus.sram_oe_n) any_oe = 1'b1;
                if (!bus.sram_we_n) any_we = 1'b1;
                if (bus.sram_dq_oe) any_dqoe = 1'b1;
                lat++;
            end
        end
        if (!done) check({tag, "_ready_timeout"}, {31'h0, bus.ready}, 32'h1);
        check({tag, "_latency"}, 32'(lat), 32'(2*HC+1));
        if (done && rd && !wr) begin
            if (rdq.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(rdq.size()), 32'h1);
            end else begin
                exp = rdq.pop_front();
                check({tag, "_read_data"}, bus.read_data, exp);
            end
        end
    endtask

    task automatic go_idle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        mem_init = 1'b1;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = '0; bus.write_data = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 16'h1000 + 16'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",     {31'h0, bus.ready},     32'h1);
        check("rst_read_data", bus.read_data,          32'h0);
        check("rst_we_n",      {31'h0, bus.sram_we_n}, 32'h1);
        check("rst_oe_n",      {31'h0, bus.sram_oe_n}, 32'h1);
        check("rst_dq_oe",     {31'h0, bus.sram_dq_oe},32'h0);
        check("rst_addr",      32'(bus.sram_addr),     32'h0);
        rst = 1'b1;
        mem_init = 1'b0;
        @(posedge clk); #1;

        // Test 1: basic write
        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, "t1");
        check("t1_dq_lo", d_lo, 32'hBEEF);
        check("t1_dq_hi", d_hi, 32'hDEAD);
        check("t1_dq_oe", {31'h0, any_dqoe}, 32'h1);
        go_idle();
        check_mem("t1");

        // Test 2: read back, then hold
        access(1'b0, 1'b1, 32'd1024, 32'h0, "t2");
        check("t2_dq_oe", {31'h0, any_dqoe}, 32'h0);
        check("t2_we",    {31'h0, any_we},   32'h0);
        go_idle();
        repeat (3) @(posedge clk);
        #1;
        check("t2_hold", bus.read_data, 32'hDEADBEEF);

        // Test 3: next word, addresses 2 then 3
        access(1'b1, 1'b0, 32'd1028, 32'h12345678, "t3");
        check("t3_addr_lo", a_lo, 32'd2);
        check("t3_addr_hi", a_hi, 32'd3);
        go_idle();
        check_mem("t3");
        check("t3_hold", bus.read_data, 32'hDEADBEEF);

        // Test 4: both requests set -> write wins
        access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, "t4");
        check("t4_oe_n_never_low", {31'h0, any_oe}, 32'h0);
        go_idle();
        check_mem("t4");

        // Test 5: back-to-back write then read, next request presented in DONE
        access(1'b1, 1'b0, 32'd1040, 32'h0BADC0DE, "t5w");
        access(1'b0, 1'b1, 32'd1040, 32'h0, "t5r");
        check("t5_gap_we_n", {31'h0, s0_we}, 32'h1);
        check("t5_gap_oe_n", {31'h0, s0_oe}, 32'h1);
        go_idle();
        check_mem("t5");

        // Test 6: reset during the HIGH half of a write
        bus.wr_en = 1'b1; bus.rd_en = 1'b0;
        bus.address = 32'd1036; bus.write_data = 32'hCAFEF00D;
        repeat (1 + 1 + HC) @(negedge clk);
        check("t6_we_n_in_high", {31'h0, bus.sram_we_n}, 32'h0);
        rst = 1'b0;
        #1;
        check("t6_we_n_reset",  {31'h0, bus.sram_we_n},  32'h1);
        check("t6_dq_oe_reset", {31'h0, bus.sram_dq_oe}, 32'h0);
        check("t6_rd_reset",    bus.read_data,           32'h0);
        bus.wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_ready_after", {31'h0, bus.ready}, 32'h1);
        check("t6_rd_after",    bus.read_data,      32'h0);
        ref_mem[6] = 16'hF00D;
        @(posedge clk); #1;
        check_mem("t6");
        access(1'b0, 1'b1, 32'd1024, 32'h0, "t6r");
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
